// File: rtl/hs32_mem_arb_if.sv
// Bus bundle for hs32_mem_arb: fetch port, execute port and shared memory bus.
// master = arbiter view, slave = requesters/memory view.
interface hs32_mem_arb_if;
    logic [31:0] f_addr;
    logic [31:0] f_dtw;
    logic        f_rw;
    logic        f_req;
    logic [31:0] f_dtr;
    logic        f_rdy;

    logic [31:0] x_addr;
    logic [31:0] x_dtw;
    logic        x_rw;
    logic        x_req;
    logic [31:0] x_dtr;
    logic        x_rdy;

    logic [31:0] m_addr;
    logic [31:0] m_dtw;
    logic        m_rw;
    logic        m_req;
    logic [31:0] m_dtr;
    logic        m_rdy;

    modport master (
        input  f_addr, f_dtw, f_rw, f_req,
        output f_dtr, f_rdy,
        input  x_addr, x_dtw, x_rw, x_req,
        output x_dtr, x_rdy,
        output m_addr, m_dtw, m_rw, m_req,
        input  m_dtr, m_rdy
    );

    modport slave (
        output f_addr, f_dtw, f_rw, f_req,
        input  f_dtr, f_rdy,
        output x_addr, x_dtw, x_rw, x_req,
        input  x_dtr, x_rdy,
        input  m_addr, m_dtw, m_rw, m_req,
        output m_dtr, m_rdy
    );
endinterface

// File: rtl/hs32_mem_arb.sv
// Two-port (fetch/execute) arbiter onto a single memory bus with registered grant.
// Define HS32_MEMARB_RR_EN for round-robin on simultaneous requests (default: exec priority).
module hs32_mem_arb (
    input  logic                  clk,
    input  logic                  reset,
    hs32_mem_arb_if.master        bus,
    output logic [1:0]            gnt,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_F = 2'd1,
        GNT_X = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   last_gnt, last_gnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= state_nxt;
            last_gnt <= last_gnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        case (state)
            IDLE: begin
                if (bus.f_req && bus.x_req) begin
`ifdef HS32_MEMARB_RR_EN
                    // Serve whichever port did not win last time.
                    if (last_gnt) begin
                        state_nxt    = GNT_F;
                        last_gnt_nxt = 1'b0;
                    end else begin
                        state_nxt    = GNT_X;
                        last_gnt_nxt = 1'b1;
                    end
`else
                    state_nxt    = GNT_X;
                    last_gnt_nxt = 1'b1;
`endif
                end else if (bus.x_req) begin
                    state_nxt    = GNT_X;
                    last_gnt_nxt = 1'b1;
                end else if (bus.f_req) begin
                    state_nxt    = GNT_F;
                    last_gnt_nxt = 1'b0;
                end
            end
            GNT_F: begin
                if (!bus.f_req || bus.m_rdy) state_nxt = IDLE;
            end
            GNT_X: begin
                if (!bus.x_req || bus.m_rdy) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.m_addr = '0;
        bus.m_dtw  = '0;
        bus.m_rw   = 1'b0;
        bus.m_req  = 1'b0;
        bus.f_rdy  = 1'b0;
        bus.x_rdy  = 1'b0;
        gnt        = 2'b00;
        case (state)
            GNT_F: begin
                bus.m_addr = bus.f_addr;
                bus.m_dtw  = bus.f_dtw;
                bus.m_rw   = bus.f_rw;
                bus.m_req  = bus.f_req;
                bus.f_rdy  = bus.m_rdy & bus.f_req;
                gnt        = 2'b01;
            end
            GNT_X: begin
                bus.m_addr = bus.x_addr;
                bus.m_dtw  = bus.x_dtw;
                bus.m_rw   = bus.x_rw;
                bus.m_req  = bus.x_req;
                bus.x_rdy  = bus.m_rdy & bus.x_req;
                gnt        = 2'b10;
            end
            default: ;
        endcase
    end

    assign bus.f_dtr = bus.m_dtr;
    assign bus.x_dtr = bus.m_dtr;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Directed-vector bench for hs32_mem_arb; expected values are hand-computed per cycle.
// Inputs change 1 time unit after the rising edge, outputs are checked 2 units later.
module tb_hs32_mem_arb;

    logic       clk;
    logic       reset;
    logic [1:0] gnt;
    logic       busy;
    int         n_vec;
    int         n_err;

    hs32_mem_arb_if bus ();

    hs32_mem_arb dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .gnt   (gnt),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next cycle: inputs may be changed right after this returns.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        bus.f_addr = '0; bus.f_dtw = '0; bus.f_rw = 1'b0; bus.f_req = 1'b0;
        bus.x_addr = '0; bus.x_dtw = '0; bus.x_rw = 1'b0; bus.x_req = 1'b0;
        bus.m_dtr  = '0; bus.m_rdy = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [1:0] exp_gnt;

    initial begin
        n_vec = 0;
        n_err = 0;
        clear_inputs();
        reset = 1'b1;
        tick();
        do_reset();
        settle();
        chk("rst_busy",  {31'd0, busy},      32'd0);
        chk("rst_gnt",   {30'd0, gnt},       32'd0);
        chk("rst_mreq",  {31'd0, bus.m_req}, 32'd0);
        chk("rst_frdy",  {31'd0, bus.f_rdy}, 32'd0);
        chk("rst_xrdy",  {31'd0, bus.x_rdy}, 32'd0);

        // Single fetch read, cycle 0 request, m_rdy in cycle 3.
        tick();
        bus.f_req = 1'b1; bus.f_addr = 32'h0000_0010; bus.f_rw = 1'b0;
        settle();
        chk("f_c0_mreq", {31'd0, bus.m_req}, 32'd0);
        chk("f_c0_addr", bus.m_addr,         32'd0);
        tick(); settle();
        chk("f_c1_mreq", {31'd0, bus.m_req}, 32'd1);
        chk("f_c1_gnt",  {30'd0, gnt},       32'd1);
        chk("f_c1_addr", bus.m_addr,         32'h10);
        chk("f_c1_busy", {31'd0, busy},      32'd1);
        chk("f_c1_frdy", {31'd0, bus.f_rdy}, 32'd0);
        tick(); settle();
        chk("f_c2_mreq", {31'd0, bus.m_req}, 32'd1);
        tick();
        bus.m_rdy = 1'b1; bus.m_dtr = 32'hDEAD_BEEF;
        settle();
        chk("f_c3_mreq", {31'd0, bus.m_req}, 32'd1);
        chk("f_c3_frdy", {31'd0, bus.f_rdy}, 32'd1);
        chk("f_c3_dtr",  bus.f_dtr,          32'hDEAD_BEEF);
        chk("f_c3_xdtr", bus.x_dtr,          32'hDEAD_BEEF);
        chk("f_c3_xrdy", {31'd0, bus.x_rdy}, 32'd0);
        // f_req stays high: the mandatory IDLE gap comes first, then a new grant.
        tick();
        bus.m_rdy = 1'b0;
        settle();
        chk("f_c4_busy", {31'd0, busy},      32'd0);
        chk("f_c4_mreq", {31'd0, bus.m_req}, 32'd0);
        chk("f_c4_frdy", {31'd0, bus.f_rdy}, 32'd0);
        chk("f_c4_addr", bus.m_addr,         32'd0);
        tick(); settle();
        chk("f_c5_mreq", {31'd0, bus.m_req}, 32'd1);
        bus.f_req = 1'b0;
        settle();
        chk("f_c5_abort_mreq", {31'd0, bus.m_req}, 32'd0);
        tick(); settle();
        chk("f_c6_busy", {31'd0, busy}, 32'd0);

        // Execute write.
        bus.x_req = 1'b1; bus.x_addr = 32'h100; bus.x_dtw = 32'h1234_5678; bus.x_rw = 1'b1;
        tick(); settle();
        chk("x_gnt",  {30'd0, gnt},       32'd2);
        chk("x_rw",   {31'd0, bus.m_rw},  32'd1);
        chk("x_dtw",  bus.m_dtw,          32'h1234_5678);
        chk("x_addr", bus.m_addr,         32'h100);
        chk("x_rdy0", {31'd0, bus.x_rdy}, 32'd0);
        tick();
        bus.m_rdy = 1'b1; bus.m_dtr = 32'h0BAD_F00D;
        settle();
        chk("x_rdy1", {31'd0, bus.x_rdy}, 32'd1);
        chk("x_frdy", {31'd0, bus.f_rdy}, 32'd0);
        tick();
        bus.m_rdy = 1'b1;
        settle();
        chk("x_rdy_once", {31'd0, bus.x_rdy}, 32'd0);
        chk("x_idle",     {31'd0, busy},      32'd0);
        bus.x_req = 1'b0; bus.x_rw = 1'b0; bus.m_rdy = 1'b0;

        // Simultaneous held requests, each served one cycle after grant.
        do_reset();
        bus.f_req = 1'b1; bus.f_addr = 32'hA0;
        bus.x_req = 1'b1; bus.x_addr = 32'hB0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("arb_idle", {31'd0, busy}, 32'd0);
`ifdef HS32_MEMARB_RR_EN
            exp_gnt = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_gnt = 2'b10;
`endif
            tick(); settle();
            chk("arb_gnt",  {30'd0, gnt},       {30'd0, exp_gnt});
            chk("arb_addr", bus.m_addr,         exp_gnt[1] ? 32'hB0 : 32'hA0);
            tick();
            bus.m_rdy = 1'b1;
            settle();
            chk("arb_frdy", {31'd0, bus.f_rdy}, {31'd0, exp_gnt[0]});
            chk("arb_xrdy", {31'd0, bus.x_rdy}, {31'd0, exp_gnt[1]});
            tick();
            bus.m_rdy = 1'b0;
        end
        bus.f_req = 1'b0; bus.x_req = 1'b0;

        // Reset in the middle of a granted fetch.
        do_reset();
        bus.f_req = 1'b1; bus.f_addr = 32'h40;
        tick(); settle();
        chk("rm_c1_gnt", {30'd0, gnt}, 32'd1);
        tick();
        reset = 1'b1;
        settle();
        chk("rm_c2_mreq", {31'd0, bus.m_req}, 32'd1);
        tick();
        reset = 1'b0; bus.f_req = 1'b0;
        settle();
        chk("rm_c3_mreq", {31'd0, bus.m_req}, 32'd0);
        chk("rm_c3_gnt",  {30'd0, gnt},       32'd0);
        tick();
        bus.m_rdy = 1'b1;
        settle();
        chk("rm_c4_frdy", {31'd0, bus.f_rdy}, 32'd0);
        chk("rm_c4_busy", {31'd0, busy},      32'd0);
        bus.m_rdy = 1'b0;

        // Fetch dropped before m_rdy, then stray m_rdy in IDLE.
        tick();
        bus.f_req = 1'b1; bus.f_addr = 32'h80;
        tick(); settle();
        chk("ab_c1_busy", {31'd0, busy}, 32'd1);
        bus.f_req = 1'b0; bus.m_rdy = 1'b1;
        settle();
        chk("ab_c1_mreq", {31'd0, bus.m_req}, 32'd0);
        chk("ab_c1_frdy", {31'd0, bus.f_rdy}, 32'd0);
        tick(); settle();
        chk("ab_c2_busy", {31'd0, busy},      32'd0);
        chk("ab_c2_gnt",  {30'd0, gnt},       32'd0);
        chk("ab_c2_frdy", {31'd0, bus.f_rdy}, 32'd0);
        chk("ab_c2_xrdy", {31'd0, bus.x_rdy}, 32'd0);
        tick(); settle();
        chk("ab_c3_busy", {31'd0, busy},      32'd0);
        chk("ab_c3_mreq", {31'd0, bus.m_req}, 32'd0);
        bus.m_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hs32_mem_arb.md
HS32_MEM_ARB -- requirements
Module: hs32_mem_arb

Interface
REQ-001 SHALL have port: clk  in  1  system clock; all state changes on its rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: f_addr  in  32, f_dtw  in  32, f_rw  in  1, f_req  in  1; fetch requester (port 0) address, write data, 1=write, request.
REQ-004 SHALL have ports: f_dtr  out  32, f_rdy  out  1; fetch read data and completion strobe.
REQ-005 SHALL have ports: x_addr  in  32, x_dtw  in  32, x_rw  in  1, x_req  in  1; execute requester (port 1), same meanings.
REQ-006 SHALL have ports: x_dtr  out  32, x_rdy  out  1; execute read data and completion strobe.
REQ-007 SHALL have ports: m_addr  out  32, m_dtw  out  32, m_rw  out  1, m_req  out  1, m_dtr  in  32, m_rdy  in  1; shared memory bus.
REQ-008 SHALL have ports: gnt  out  2  one-hot grant (bit0 fetch, bit1 exec); busy  out  1  transaction in flight.

Function
REQ-009 SHALL implement FSM states IDLE, GNT_F, GNT_X.
REQ-010 IDLE: no request -> stay; one request -> grant that port next cycle; both -> arbitration per REQ-020/021.
REQ-011 Grant SHALL be registered: request sampled in IDLE at cycle N -> m_req=1 and gnt set from cycle N+1.
REQ-012 In GNT_F/GNT_X, m_addr, m_dtw, m_rw SHALL combinationally mirror the granted port; in IDLE they SHALL be 0.
REQ-013 m_req SHALL equal (state != IDLE) AND granted port's req.
REQ-014 f_rdy = (state==GNT_F) AND m_rdy AND f_req; x_rdy likewise for GNT_X; non-granted rdy SHALL be 0.
REQ-015 f_dtr and x_dtr SHALL both be driven by m_dtr unconditionally; data is valid only in the rdy cycle.
REQ-016 Cycle where granted req and m_rdy both high -> state returns to IDLE next cycle (exactly one rdy pulse per transaction).
REQ-017 Granted req deasserting before m_rdy -> abort: IDLE next cycle, m_req=0, no rdy pulse.
REQ-018 m_rdy in IDLE SHALL be ignored; no rdy pulse, no state change.
REQ-019 Minimum spacing: completion at cycle M -> earliest next m_req at M+2 (one IDLE cycle).
REQ-020 Default arbitration: fixed priority, exec over fetch, on simultaneous requests.
REQ-021 A single-bit last-grant register SHALL be updated on every grant (0=fetch, 1=exec).
REQ-022 busy SHALL equal (state != IDLE); gnt SHALL be 2'b00 in IDLE.

Reset
REQ-023 On reset: state=IDLE, last-grant=1 (exec), m_req=0, gnt=0, busy=0, f_rdy=x_rdy=0.
REQ-024 Reset asserted mid-transaction SHALL abort it; m_req=0 from the cycle after reset is sampled; no rdy pulse issued.

Configuration
REQ-025 Macro HS32_MEMARB_RR_EN: when defined, simultaneous requests SHALL be granted to the port NOT in last-grant (round-robin); when undefined, REQ-020 fixed priority applies and last-grant is only observable, not used.

Verification
REQ-026 Single fetch: f_req=1, f_addr=0x0000_0010, f_rw=0 at cycle 0; m_rdy=1 with m_dtr=0xDEAD_BEEF at cycle 3 -> m_req=1 in cycles 1-3, m_addr=0x10, f_rdy=1 and f_dtr=0xDEADBEEF in cycle 3, IDLE in cycle 4.
REQ-027 Simultaneous f_req and x_req held (no macro), each served with m_rdy one cycle after grant -> grant order X,F,X,F... never; order X, X, X... while x_req stays asserted (fetch starved).
REQ-028 Same as REQ-027 with HS32_MEMARB_RR_EN -> grant order after reset F, X, F, X; each transaction followed by one IDLE cycle.
REQ-029 Exec write x_addr=0x100, x_dtw=0x1234_5678, x_rw=1 -> m_rw=1, m_dtw=0x12345678 while GNT_X; x_rdy pulse of exactly one cycle on m_rdy.
REQ-030 Reset pulse at cycle 2 of a granted fetch awaiting m_rdy -> m_req=0, gnt=0 from cycle 3; late m_rdy at cycle 4 produces no f_rdy.
REQ-031 f_req dropped before m_rdy -> IDLE next cycle, no f_rdy; then m_rdy=1 in IDLE -> ignored.
